// File: rtl/jsp_bus_pkg.sv
// jsp_bus_pkg: shared responder state encoding and parameter defaults.
package jsp_bus_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ACK,
        ST_GRANT
    } resp_state_t;
    localparam int DEF_WAIT_STATES    = 1;
    localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/down_counter.sv
// down_counter: loadable down counter that parks at zero.
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);
    logic [WIDTH-1:0] count;
    assign zero = count == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (load) count <= load_val;
        else if (en && !zero) count <= count - WIDTH'(1);
    end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: main-bus RAM access sequencer with external-master grant; MEM_RESP_WATCHDOG_EN adds a grant watchdog.
module mem_bus_responder
    import jsp_bus_pkg::*;
#(
    parameter int WAIT_STATES    = DEF_WAIT_STATES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_assert_main,
    input  logic        mem_load_main,
    input  logic        bus_request,
    input  logic [15:0] addr,
    input  logic [7:0]  bus_in,
    input  logic [7:0]  ram_rdata,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    output logic        mem_ack,
    output logic        stall,
    output logic        bus_grant,
    output logic        timeout_err
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    resp_state_t state;
    logic        is_read, wait_zero, grant_ok, mem_req;
    logic [7:0]  bus_hold;
    assign mem_req = !mem_assert_main || !mem_load_main;
    // RAM data arrives during ACK, so it is passed through then and held afterwards
    assign bus_out = bus_oe ? ram_rdata : bus_hold;
`ifdef MEM_RESP_WATCHDOG_EN
    logic lockout, wd_zero;
    assign grant_ok = bus_request && !lockout;
    down_counter #(.WIDTH(8)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_IDLE && grant_ok),
        .en       (state == ST_GRANT),
        .load_val (8'(TIMEOUT_CYCLES - 1)),
        .zero     (wd_zero)
    );
`else
    assign grant_ok = bus_request;
`endif
    down_counter #(.WIDTH(4)) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_IDLE && !grant_ok && mem_req),
        .en       (state == ST_WAIT),
        .load_val (WAIT_LOAD),
        .zero     (wait_zero)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            bus_hold    <= '0;
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            bus_oe      <= 1'b0;
            mem_ack     <= 1'b1;
            stall       <= 1'b0;
            bus_grant   <= 1'b0;
            timeout_err <= 1'b0;
            is_read     <= 1'b0;
`ifdef MEM_RESP_WATCHDOG_EN
            lockout     <= 1'b0;
`endif
        end else begin
            ram_we  <= 1'b0;
            ram_re  <= 1'b0;
            bus_oe  <= 1'b0;
            mem_ack <= 1'b1;
`ifdef MEM_RESP_WATCHDOG_EN
            if (!bus_request) lockout <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (grant_ok) begin
                        state     <= ST_GRANT;
                        bus_grant <= 1'b1;
                        stall     <= 1'b1;
                    end else if (mem_req) begin
                        state       <= WAIT_STATES == 0 ? ST_ACCESS : ST_WAIT;
                        stall       <= 1'b1;
                        ram_addr    <= addr;
                        ram_wdata   <= bus_in;
                        is_read     <= !mem_assert_main;
                        timeout_err <= timeout_err || (!mem_assert_main && !mem_load_main);
                        if (WAIT_STATES == 0) begin
                            ram_re <= !mem_assert_main;
                            ram_we <= mem_assert_main;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_zero) begin
                        state  <= ST_ACCESS;
                        ram_re <= is_read;
                        ram_we <= !is_read;
                    end
                end
                ST_ACCESS: begin
                    state   <= ST_ACK;
                    stall   <= 1'b0;
                    mem_ack <= 1'b0;
                    bus_oe  <= is_read;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    if (is_read) bus_hold <= ram_rdata;
                end
                ST_GRANT: begin
                    if (!bus_request) begin
                        state     <= ST_IDLE;
                        bus_grant <= 1'b0;
                        stall     <= 1'b0;
                    end
`ifdef MEM_RESP_WATCHDOG_EN
                    else if (wd_zero) begin
                        state       <= ST_IDLE;
                        bus_grant   <= 1'b0;
                        stall       <= 1'b0;
                        timeout_err <= 1'b1;
                        lockout     <= 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed checks on a one-wait-state and a zero-wait-state responder.
module tb_mem_bus_responder;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ma = 1'b1, ml = 1'b1, br = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  bus_in = '0, rdata1 = '0, rdata0 = '0;
    logic [15:0] ram_addr1, ram_addr0;
    logic [7:0]  wdata1, wdata0, bus_out1, bus_out0;
    logic        we1, re1, oe1, ack1, stall1, grant1, terr1;
    logic        we0, re0, oe0, ack0, stall0, grant0, terr0;
    logic [7:0]  mem [16];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(.WAIT_STATES(1), .TIMEOUT_CYCLES(4)) u1 (
        .clk(clk), .rst_n(rst_n), .mem_assert_main(ma), .mem_load_main(ml), .bus_request(br),
        .addr(addr), .bus_in(bus_in), .ram_rdata(rdata1), .ram_addr(ram_addr1), .ram_wdata(wdata1),
        .ram_we(we1), .ram_re(re1), .bus_out(bus_out1), .bus_oe(oe1), .mem_ack(ack1),
        .stall(stall1), .bus_grant(grant1), .timeout_err(terr1)
    );
    mem_bus_responder #(.WAIT_STATES(0), .TIMEOUT_CYCLES(4)) u0 (
        .clk(clk), .rst_n(rst_n), .mem_assert_main(ma), .mem_load_main(ml), .bus_request(br),
        .addr(addr), .bus_in(bus_in), .ram_rdata(rdata0), .ram_addr(ram_addr0), .ram_wdata(wdata0),
        .ram_we(we0), .ram_re(re0), .bus_out(bus_out0), .bus_oe(oe0), .mem_ack(ack0),
        .stall(stall0), .bus_grant(grant0), .timeout_err(terr0)
    );

    always @(posedge clk) begin
        if (re1) rdata1 <= mem[ram_addr1[3:0]];
        if (re0) rdata0 <= mem[ram_addr0[3:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);
        mem[4] = 8'hA5;
        tick();
        tick();
        chk("rst_ack", 16'(ack1), 16'h1);
        chk("rst_stall", 16'(stall1), 16'h0);
        chk("rst_grant", 16'(grant1), 16'h0);
        chk("rst_bus_out", 16'(bus_out1), 16'h0);
        chk("rst_ram_addr", ram_addr1, 16'h0);
        chk("rst_re_we_oe_terr", {12'h0, re1, we1, oe1, terr1}, 16'h0);
        rst_n = 1'b1;
        tick();
        // read on the one-wait-state instance
        addr = 16'h1234;
        ma = 1'b0;
        tick();
        chk("rd_c1_stall", 16'(stall1), 16'h1);
        chk("rd_c1_re", 16'(re1), 16'h0);
        ma = 1'b1;
        addr = 16'h0000;
        tick();
        chk("rd_c2_re", 16'(re1), 16'h1);
        chk("rd_c2_addr", ram_addr1, 16'h1234);
        chk("rd_c2_ack", 16'(ack1), 16'h1);
        tick();
        chk("rd_c3_ack", 16'(ack1), 16'h0);
        chk("rd_c3_oe", 16'(oe1), 16'h1);
        chk("rd_c3_bus_out", 16'(bus_out1), 16'h00A5);
        chk("rd_c3_re_stall", {14'h0, re1, stall1}, 16'h0);
        tick();
        chk("rd_c4_ack_oe", {14'h0, ack1, oe1}, 16'h2);
        chk("rd_c4_bus_out_hold", 16'(bus_out1), 16'h00A5);
        tick();
        // write on the zero-wait-state instance
        addr = 16'h0010;
        bus_in = 8'h3C;
        ml = 1'b0;
        tick();
        chk("wr_c1_we", 16'(we0), 16'h1);
        chk("wr_c1_addr", ram_addr0, 16'h0010);
        chk("wr_c1_wdata", 16'(wdata0), 16'h003C);
        chk("wr_c1_ack", 16'(ack0), 16'h1);
        ml = 1'b1;
        bus_in = 8'h00;
        tick();
        chk("wr_c2_ack", 16'(ack0), 16'h0);
        chk("wr_c2_we_oe", {14'h0, we0, oe0}, 16'h0);
        tick();
        chk("wr_c3_ack", 16'(ack0), 16'h1);
        chk("wr_hold_addr", ram_addr0, 16'h0010);
        chk("wr_hold_wdata", 16'(wdata0), 16'h003C);
        tick();
        tick();
        // grant wins over a simultaneous read; read served after release
        addr = 16'h0004;
        ma = 1'b0;
        br = 1'b1;
        tick();
        chk("col_c1_grant", 16'(grant1), 16'h1);
        chk("col_c1_stall_re", {14'h0, stall1, re1}, 16'h2);
        tick();
        chk("col_c2_grant", 16'(grant1), 16'h1);
        br = 1'b0;
        tick();
        chk("col_c3_grant", 16'(grant1), 16'h0);
        chk("col_c3_stall", 16'(stall1), 16'h0);
        tick();
        chk("col_c4_stall", 16'(stall1), 16'h1);
        ma = 1'b1;
        tick();
        chk("col_c5_re", 16'(re1), 16'h1);
        tick();
        chk("col_c6_ack", 16'(ack1), 16'h0);
        chk("col_c6_bus_out", 16'(bus_out1), 16'h00A5);
        tick();
        tick();
        // reset during WAIT aborts the access
        addr = 16'h1234;
        ma = 1'b0;
        tick();
        chk("rst_mid_stall_before", 16'(stall1), 16'h1);
        ma = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", 16'(stall1), 16'h0);
        chk("rst_mid_ram_addr", ram_addr1, 16'h0);
        chk("rst_mid_re_ack", {14'h0, re1, ack1}, 16'h1);
        tick();
        chk("rst_mid_c2_re_ack", {14'h0, re1, ack1}, 16'h1);
        rst_n = 1'b1;
        tick();
        chk("rst_mid_c3_re_ack", {14'h0, re1, ack1}, 16'h1);
        tick();
        chk("rst_mid_c4_re_ack", {14'h0, re1, ack1}, 16'h1);
        chk("rst_mid_terr", 16'(terr1), 16'h0);
        // both requests low: read plus sticky error
        addr = 16'h0004;
        ma = 1'b0;
        ml = 1'b0;
        tick();
        chk("cf_c1_terr", 16'(terr1), 16'h1);
        ma = 1'b1;
        ml = 1'b1;
        tick();
        chk("cf_c2_re_we", {14'h0, re1, we1}, 16'h2);
        tick();
        chk("cf_c3_ack_bus_out", {7'h0, ack1, bus_out1}, 16'h00A5);
        tick();
        tick();
        chk("cf_sticky", 16'(terr1), 16'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("wd_pre_terr", 16'(terr1), 16'h0);
        // grant held: bounded only with the watchdog compiled in
        br = 1'b1;
        tick();
        chk("wd_c1_grant", 16'(grant1), 16'h1);
        tick();
        tick();
        tick();
        chk("wd_c4_grant", 16'(grant1), 16'h1);
        tick();
`ifdef MEM_RESP_WATCHDOG_EN
        chk("wd_c5_grant", 16'(grant1), 16'h0);
        chk("wd_c5_terr", 16'(terr1), 16'h1);
        tick();
        chk("wd_lockout", 16'(grant1), 16'h0);
`else
        chk("wd_c5_grant", 16'(grant1), 16'h1);
        chk("wd_c5_terr", 16'(terr1), 16'h0);
        tick();
        chk("wd_unbounded", 16'(grant1), 16'h1);
`endif
        br = 1'b0;
        tick();
        chk("wd_release", 16'(grant1), 16'h0);
        br = 1'b1;
        tick();
        chk("wd_regrant", 16'(grant1), 16'h1);
        br = 1'b0;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, setting the memory wait cycles inserted per access (legal range 0..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, setting the grant watchdog limit, used only when the watchdog is compiled in.
REQ-003 SHALL have port `clk`  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port `rst_n`  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port `mem_assert_main`  in  1  active-low read request: memory drives the main bus.
REQ-006 SHALL have port `mem_load_main`  in  1  active-low write request: memory loads from the main bus.
REQ-007 SHALL have port `bus_request`  in  1  active-high external-master bus request (control bit 13).
REQ-008 SHALL have port `addr`  in  16  address from the selected address-bus source.
REQ-009 SHALL have port `bus_in`  in  8  main-bus data used for writes.
REQ-010 SHALL have port `ram_rdata`  in  8  RAM read data, valid one cycle after `ram_re`.
REQ-011 SHALL have port `ram_addr`  out  16  RAM address.
REQ-012 SHALL have port `ram_wdata`  out  8  RAM write data.
REQ-013 SHALL have ports `ram_we` and `ram_re`  out  1 each  active-high single-cycle strobes.
REQ-014 SHALL have port `bus_out`  out  8  read data presented to the main bus.
REQ-015 SHALL have port `bus_oe`  out  1  active-high main-bus drive enable.
REQ-016 SHALL have port `mem_ack`  out  1  active-low access-complete pulse.
REQ-017 SHALL have port `stall`  out  1  active-high pipeline hold.
REQ-018 SHALL have ports `bus_grant` and `timeout_err`  out  1 each  active-high grant to the external master, and sticky watchdog error.

Function
REQ-019 SHALL implement a state machine with states IDLE, WAIT, ACCESS, ACK and GRANT.
REQ-020 IDLE: if `bus_request` is high, SHALL go to GRANT; otherwise, if either request input is low, SHALL latch `addr`, `bus_in` and the direction, then go to WAIT (WAIT_STATES > 0) or ACCESS (WAIT_STATES = 0).
REQ-021 When `bus_request` and a memory request coincide in IDLE, `bus_request` SHALL win; the memory request SHALL be served after the grant is released, provided it is still asserted.
REQ-022 If `mem_assert_main` and `mem_load_main` are both low, SHALL treat the access as a read and set `timeout_err`, which is sticky.
REQ-023 WAIT: SHALL count WAIT_STATES cycles using a 4-bit counter, then go to ACCESS.
REQ-024 ACCESS: SHALL pulse `ram_re` (read) or `ram_we` with the latched data (write) for exactly one cycle, then go to ACK.
REQ-025 ACK: SHALL drive `mem_ack` low for exactly one cycle; on a read, SHALL capture `ram_rdata` into `bus_out` and hold `bus_oe` high for that cycle; SHALL then go to IDLE.
REQ-026 Latency from request detect to `mem_ack` low SHALL be WAIT_STATES + 2 cycles.
REQ-027 `stall` SHALL be high in WAIT, in ACCESS, and in GRANT; it SHALL be low in IDLE and ACK.
REQ-028 GRANT: SHALL hold `bus_grant` high while `bus_request` is high, and SHALL return to IDLE on the cycle after `bus_request` falls.
REQ-029 Request inputs that change during WAIT or ACCESS SHALL be ignored; the latched values are used.
REQ-030 `ram_addr` and `ram_wdata` SHALL hold their latched values between accesses.

Reset
REQ-031 While `rst_n` is low, the block SHALL be in IDLE with: `ram_addr` = 0, `ram_wdata` = 0, `bus_out` = 0, `ram_we` = 0, `ram_re` = 0, `bus_oe` = 0, `stall` = 0, `bus_grant` = 0, `timeout_err` = 0, `mem_ack` = 1, and all counters = 0.
REQ-032 A reset asserted mid-access SHALL abort the access with no `mem_ack` pulse and no RAM strobe.

Configuration
REQ-033 With MEM_RESP_WATCHDOG_EN defined, an 8-bit counter SHALL count GRANT cycles; on reaching TIMEOUT_CYCLES it SHALL force `bus_grant` low, set `timeout_err`, and return to IDLE; `bus_request` is then ignored until it has been seen low.
REQ-034 Without MEM_RESP_WATCHDOG_EN, GRANT SHALL be unbounded and `timeout_err` SHALL be set only by REQ-022.

Structure
REQ-035 The state encoding and the WAIT_STATES and TIMEOUT_CYCLES defaults SHALL live in the shared package `jsp_bus_pkg`.
REQ-036 The wait/watchdog counter SHALL be a sub-module named `down_counter`; all other logic is flat.

Verification
REQ-037 Read test: WAIT_STATES=1, `mem_assert_main` low, `addr`=0x1234, RAM returns 0xA5 -> `ram_re` pulses at cycle 2, `mem_ack` goes low at cycle 3, `bus_out`=0xA5 with `bus_oe` high.
REQ-038 Write test: WAIT_STATES=0, `mem_load_main` low, `bus_in`=0x3C, `addr`=0x0010 -> `ram_we` pulses at cycle 1 with `ram_addr`=0x0010 and `ram_wdata`=0x3C, and `mem_ack` goes low at cycle 2.
REQ-039 Collision test: `bus_request` and a read request arrive in the same cycle -> `bus_grant` rises first; the read completes after `bus_request` drops.
REQ-040 Reset test: `rst_n` pulsed low during WAIT -> all outputs at reset values immediately; no `ram_re` and no `mem_ack`.
REQ-041 Watchdog test: MEM_RESP_WATCHDOG_EN defined, TIMEOUT_CYCLES=4, `bus_request` held high -> `bus_grant` drops after 4 cycles and `timeout_err` is set.
REQ-042 Conflict test: both request inputs low -> a read occurs and `timeout_err` is set.
